// File: rtl/crc_append_tx.sv
// CRC trailer generator: forwards a SOP/EOP framed stream through one
// output register and appends the payload CRC as trailer word(s).
module crc_append_tx #(
  parameter int               DATA_W         = 32,
  parameter int               CRC_W          = 16,
  parameter logic [CRC_W-1:0] CRC_POLY       = 16'h1021,
  parameter logic [CRC_W-1:0] CRC_INIT       = 16'hFFFF,
  parameter logic [CRC_W-1:0] CRC_XOROUT     = 16'h0000,
  parameter int               CRC_SKIP_WORDS = 1
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iWrSop,
  input  logic              iWrEop,
  input  logic              iWrVld,
  input  logic [DATA_W-1:0] iWrData,
  output logic              oFull,
  output logic              oWrSop,
  output logic              oWrEop,
  output logic              oWrVld,
  output logic [DATA_W-1:0] oWrData,
  input  logic              iFifoFull,
  output logic              oProtoErr
);

  localparam int NTRL = (CRC_W + DATA_W - 1) / DATA_W;
  localparam int TW   = (NTRL > 1) ? $clog2(NTRL) : 1;

  typedef enum logic [1:0] {IDLE, BODY, TRL} state_e;

  state_e              state_q, state_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic [3:0]          skip_q, skip_d;
  logic [TW-1:0]       trl_q, trl_d;
  logic                vld_q, vld_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                    adv, acc, upd;
  logic [CRC_W-1:0]        crc_base, crc_nxt;
  logic [3:0]              skip_base, skip_inc;
  logic [NTRL*DATA_W-1:0]  trl_vec;
  logic [DATA_W-1:0]       trl_word;

  function automatic logic [CRC_W-1:0] crc_step(
    input logic [CRC_W-1:0]  c,
    input logic [DATA_W-1:0] d
  );
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ d[i];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return r;
  endfunction

  assign adv   = !vld_q || !iFifoFull;
  assign oFull = !adv || (state_q == TRL);
  assign acc   = iWrVld && !oFull;

  // A new packet restarts CRC and skip count from their initial values
  always_comb begin
    crc_base  = (state_q == IDLE) ? CRC_INIT : crc_q;
    skip_base = (state_q == IDLE) ? 4'd0 : skip_q;
    skip_inc  = (skip_base == 4'hF) ? skip_base : skip_base + 4'd1;
    upd       = skip_base >= 4'(CRC_SKIP_WORDS);
    crc_nxt   = crc_step(crc_base, iWrData);
    trl_vec   = '0;
    trl_vec[CRC_W-1:0] = crc_q ^ CRC_XOROUT;
    trl_word  = '0;
    for (int k = 0; k < NTRL; k++) begin
      if (trl_q == TW'(NTRL - 1 - k)) begin
        trl_word = trl_vec[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    skip_d  = skip_q;
    trl_d   = trl_q;
    vld_d   = vld_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    data_d  = data_q;
    err_d   = 1'b0;
    if (adv) begin
      vld_d = 1'b0;
      sop_d = 1'b0;
      eop_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          if (iWrSop) begin
            vld_d   = 1'b1;
            sop_d   = 1'b1;
            data_d  = iWrData;
            crc_d   = upd ? crc_nxt : crc_base;
            skip_d  = skip_inc;
            trl_d   = '0;
            state_d = iWrEop ? TRL : BODY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BODY: begin
        if (acc) begin
          vld_d  = 1'b1;
          data_d = iWrData;
          crc_d  = upd ? crc_nxt : crc_base;
          skip_d = skip_inc;
          err_d  = iWrSop;
          if (iWrEop) begin
            trl_d   = '0;
            state_d = TRL;
          end
        end
      end
      TRL: begin
        if (adv) begin
          vld_d  = 1'b1;
          data_d = trl_word;
          if (trl_q == TW'(NTRL - 1)) begin
            eop_d   = 1'b1;
            state_d = IDLE;
          end else begin
            trl_d = trl_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      crc_q   <= CRC_INIT;
      skip_q  <= '0;
      trl_q   <= '0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      skip_q  <= skip_d;
      trl_q   <= trl_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign oWrVld    = vld_q;
  assign oWrSop    = sop_q;
  assign oWrEop    = eop_q;
  assign oWrData   = data_q;
  assign oProtoErr = err_q;

endmodule

// File: tb/tb_crc_append_tx.sv
// Bench for crc_append_tx: packet-level CRC model (polynomial long
// division) plus directed vectors on three parameterisations.
module tb_crc_append_tx;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
  } exp_t;

  logic clk, rst_n;

  logic        a_sop, a_eop, a_vld, a_full, a_osop, a_oeop, a_ovld;
  logic        a_err, a_ff;
  logic [31:0] a_d, a_od;

  logic        b_sop, b_eop, b_vld, b_full, b_osop, b_oeop, b_ovld;
  logic        b_err, b_ff;
  logic [7:0]  b_d, b_od;

  logic        c_sop, c_eop, c_vld, c_full, c_osop, c_oeop, c_ovld;
  logic        c_err, c_ff;
  logic [31:0] c_d, c_od;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [31:0] pk[$];
  bit   bq[$];
  logic in_pkt = 0;
  logic stall_en = 0;
  logic [31:0] last_trl = '0;
  logic [7:0]  qb_d[$];
  logic        qb_s[$];
  logic        qb_e[$];
  logic        cap_b = 0;

  crc_append_tx u_a (
    .iClk(clk), .iRst_n(rst_n), .iWrSop(a_sop), .iWrEop(a_eop),
    .iWrVld(a_vld), .iWrData(a_d), .oFull(a_full), .oWrSop(a_osop),
    .oWrEop(a_oeop), .oWrVld(a_ovld), .oWrData(a_od),
    .iFifoFull(a_ff), .oProtoErr(a_err)
  );

  crc_append_tx #(
    .DATA_W(8), .CRC_W(16), .CRC_SKIP_WORDS(0)
  ) u_b (
    .iClk(clk), .iRst_n(rst_n), .iWrSop(b_sop), .iWrEop(b_eop),
    .iWrVld(b_vld), .iWrData(b_d), .oFull(b_full), .oWrSop(b_osop),
    .oWrEop(b_oeop), .oWrVld(b_ovld), .oWrData(b_od),
    .iFifoFull(b_ff), .oProtoErr(b_err)
  );

  crc_append_tx #(
    .DATA_W(32), .CRC_W(32), .CRC_POLY(32'h04C11DB7),
    .CRC_INIT(32'hFFFFFFFF), .CRC_XOROUT(32'h0), .CRC_SKIP_WORDS(0)
  ) u_c (
    .iClk(clk), .iRst_n(rst_n), .iWrSop(c_sop), .iWrEop(c_eop),
    .iWrVld(c_vld), .iWrData(c_d), .oFull(c_full), .oWrSop(c_osop),
    .oWrEop(c_oeop), .oWrVld(c_ovld), .oWrData(c_od),
    .iFifoFull(c_ff), .oProtoErr(c_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic void add_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
  endfunction

  // Remainder of (msg*x^w + init*x^len) mod G, by long division
  function automatic logic [63:0] crc_div(input int w,
      input logic [63:0] poly, input logic [63:0] init);
    bit m[$];
    logic [64:0] g;
    logic [63:0] r;
    m = bq;
    for (int i = 0; i < w; i++) m.push_back(1'b0);
    for (int i = 0; i < w; i++) m[i] = m[i] ^ init[w-1-i];
    g = {1'b0, poly} | (65'd1 << w);
    for (int i = 0; i + w < m.size(); i++)
      if (m[i])
        for (int j = 0; j <= w; j++) m[i+j] = m[i+j] ^ g[w-j];
    r = '0;
    for (int i = 0; i < w; i++) r[w-1-i] = m[m.size()-w+i];
    return r;
  endfunction

  function automatic void model_accept(input logic [31:0] d,
      input logic s, input logic e);
    logic [15:0] crc;
    if (!in_pkt) begin
      if (!s) return;
      in_pkt = 1;
      pk.delete();
      exp_q.push_back('{d, 1'b1, 1'b0});
    end else begin
      exp_q.push_back('{d, 1'b0, 1'b0});
    end
    pk.push_back(d);
    if (e) begin
      bq.delete();
      for (int k = 1; k < pk.size(); k++) add_bits(pk[k], 32);
      crc = 16'(crc_div(16, 64'h1021, 64'hFFFF)) ^ 16'h0000;
      exp_q.push_back('{{16'h0, crc}, 1'b0, 1'b1});
      in_pkt = 0;
    end
  endfunction

  task automatic send_a(input logic [31:0] d, input logic s,
                        input logic e, output int waited);
    logic ok;
    ok = 0;
    waited = 0;
    a_vld = 1; a_d = d; a_sop = s; a_eop = e;
    while (!ok && waited < 1000) begin
      @(negedge clk);
      if (!a_full) ok = 1;
      else begin
        waited++;
        @(posedge clk); #1;
      end
    end
    if (ok) begin
      @(posedge clk);
      model_accept(d, s, e);
      #1;
    end else begin
      chk("send_timeout", 1, 0);
    end
    a_vld = 0; a_sop = 0; a_eop = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || a_ovld) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(exp_q.size()), 0);
  endtask

  initial begin
    a_ff = 0;
    forever begin
      @(posedge clk); #1;
      a_ff = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Scoreboard on every transfer plus hold-stable check while stalled
  initial begin
    exp_t e;
    logic hold, hs, he;
    logic [31:0] hd;
    hold = 0; hs = 0; he = 0; hd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
        continue;
      end
      if (hold) begin
        chk("stall_hold", {a_ovld, a_osop, a_oeop, a_od},
            {1'b1, hs, he, hd});
      end
      if (a_ovld && !a_ff) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", a_od, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("stream_data", a_od, e.d);
          chk("stream_flags", {a_osop, a_oeop}, {e.s, e.e});
          if (a_oeop) last_trl = a_od;
        end
      end
      hold = a_ovld && a_ff;
      hs = a_osop; he = a_oeop; hd = a_od;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cap_b && b_ovld) begin
        qb_d.push_back(b_od);
        qb_s.push_back(b_osop);
        qb_e.push_back(b_oeop);
      end
    end
  end

  initial begin
    int w;
    int len;
    logic [31:0] c_exp;
    rst_n = 0;
    a_vld = 0; a_sop = 0; a_eop = 0; a_d = '0;
    b_vld = 0; b_sop = 0; b_eop = 0; b_d = '0; b_ff = 0;
    c_vld = 0; c_sop = 0; c_eop = 0; c_d = '0; c_ff = 0;

    bq.delete();
    for (int i = 0; i < 9; i++) add_bits(64'(8'h31 + i), 8);
    chk("model_ccitt", crc_div(16, 64'h1021, 64'hFFFF), 64'h29B1);
    chk("model_mpeg2", crc_div(32, 64'h04C11DB7, 64'hFFFFFFFF),
        64'h0376E6E7);

    #12;
    chk("rst_out", {a_ovld, a_osop, a_oeop, a_err, a_full, a_od}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // 3-word packet, SOP word skipped
    send_a(32'hA5A5_0001, 1, 0, w);
    chk("t1_wait0", w, 0);
    send_a(32'h0, 0, 0, w);
    chk("t1_wait1", w, 0);
    send_a(32'h0, 0, 1, w);
    chk("t1_wait2", w, 0);
    @(negedge clk);
    chk("t1_last_payload", {a_ovld, a_oeop, a_od}, {1'b1, 1'b0, 32'h0});
    @(negedge clk);
    chk("t1_trailer_flags", {a_ovld, a_oeop, a_osop}, 3'b110);
    chk("t1_trailer_hi", a_od[31:16], 0);
    @(posedge clk); #1;
    wait_drain();

    // Packet inside skip window, then back-to-back SOP
    send_a(32'h1234_5678, 1, 1, w);
    send_a(32'hCAFE_0000, 1, 0, w);
    chk("t4_b2b_wait", w, 1);
    chk("t4_skip_trl", last_trl, 32'h0000_FFFF);
    send_a(32'h0000_0001, 0, 1, w);
    wait_drain();

    // Non-SOP word in IDLE
    send_a(32'hDEAD_BEEF, 0, 0, w);
    @(negedge clk);
    chk("t6_err_pulse", a_err, 1);
    @(negedge clk);
    chk("t6_err_clear", a_err, 0);
    @(posedge clk); #1;

    // 200 packets under random sink stall
    stall_en = 1;
    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        send_a($urandom, k == 0, k == len - 1, w);
    end
    stall_en = 0;
    @(posedge clk); #1;
    wait_drain();

    // Reset mid-body
    send_a(32'h1111_0000, 1, 0, w);
    send_a(32'h2222_0000, 0, 0, w);
    #2;
    rst_n = 0;
    #1;
    chk("t6_rst_async", {a_ovld, a_osop, a_oeop, a_err, a_full, a_od}, 0);
    exp_q.delete();
    in_pkt = 0;
    @(negedge clk); #2;
    rst_n = 1;
    @(posedge clk); #1;
    send_a(32'h3333_0000, 1, 0, w);
    send_a(32'h0BAD_F00D, 0, 0, w);
    send_a(32'h0000_0042, 0, 1, w);
    wait_drain();

    // 8-bit CRC-16/CCITT-FALSE check string
    cap_b = 1;
    b_vld = 1;
    for (int i = 0; i < 9; i++) begin
      b_d = 8'h31 + 8'(i);
      b_sop = (i == 0);
      b_eop = (i == 8);
      @(negedge clk);
      chk("b_full", b_full, 0);
      @(posedge clk); #1;
    end
    b_vld = 0; b_sop = 0; b_eop = 0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("b_count", 64'(qb_d.size()), 11);
    if (qb_d.size() == 11) begin
      chk("b_first_sop", {qb_s[0], qb_d[0]}, {1'b1, 8'h31});
      chk("b_trl0", {qb_e[9], qb_d[9]}, {1'b0, 8'h29});
      chk("b_trl1", {qb_e[10], qb_d[10]}, {1'b1, 8'hB1});
    end

    // 32-bit CRC on a single SOP&EOP word
    bq.delete();
    add_bits(64'h31323334, 32);
    c_exp = 32'(crc_div(32, 64'h04C11DB7, 64'hFFFFFFFF));
    c_vld = 1; c_sop = 1; c_eop = 1; c_d = 32'h3132_3334;
    @(negedge clk);
    chk("c_full_idle", c_full, 0);
    @(posedge clk); #1;
    c_vld = 0; c_sop = 0; c_eop = 0;
    @(negedge clk);
    chk("c_full_trl", c_full, 1);
    chk("c_word0", {c_ovld, c_osop, c_oeop, c_od},
        {3'b110, 32'h3132_3334});
    @(negedge clk);
    chk("c_full_after", c_full, 0);
    chk("c_trailer", {c_ovld, c_osop, c_oeop, c_od}, {3'b101, c_exp});
    @(negedge clk);
    chk("c_only_two", c_ovld, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
